// File: rtl/cascade_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_counter
//  Description : Parametrised multi-digit up/down counter. Each digit counts
//                modulo BASE (BASE=10 gives BCD). Supports synchronous clear,
//                parallel load with per-digit clamping, and wrap or saturate
//                at the limits. Provides a combinational terminal count for
//                chaining, a one-cycle wrap pulse and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module cascade_counter #(
    parameter int DIGITS   = 4,
    parameter int BASE     = 10,
    parameter int DIGIT_W  = 4,
    parameter int SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        rst,       // asynchronous, active-low
    input  logic                        en,
    input  logic                        up,
    input  logic                        clr,
    input  logic                        load,
    input  logic [DIGITS*DIGIT_W-1:0]   load_val,
    input  logic                        ovf_clr,
    output logic [DIGITS*DIGIT_W-1:0]   count,
    output logic                        tc,
    output logic                        wrap,
    output logic                        ovf
);

    localparam int                 c_CW   = DIGITS * DIGIT_W;
    // One extra bit so BASE == 2**DIGIT_W is representable for the clamp compare.
    localparam logic [DIGIT_W:0]   c_BASE = (DIGIT_W + 1)'(BASE);
    localparam logic [DIGIT_W-1:0] c_MAXD = DIGIT_W'(BASE - 1);

    // Reject configurations where a digit cannot hold BASE-1.
    generate
        if ((DIGITS < 1) || (BASE < 2) || (DIGIT_W < $clog2(BASE))) begin : g_bad_cfg
            $error("cascade_counter: illegal DIGITS/BASE/DIGIT_W combination");
        end
    endgenerate

    logic [c_CW-1:0]   r_count;
    logic              r_wrap;
    logic              r_ovf;

    logic [DIGITS-1:0] w_is_max;     // digit i equals BASE-1
    logic [DIGITS-1:0] w_is_zero;    // digit i equals 0
    logic [c_CW-1:0]   w_stepped;    // value after one up/down step
    logic [c_CW-1:0]   w_loaded;     // load_val with out-of-range digits clamped
    logic              w_at_term;
    logic              w_step;
    logic              w_event;

    // Per-digit compare, step and clamp logic.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_digit
            logic [DIGIT_W-1:0] w_d;
            logic [DIGIT_W-1:0] w_ld;
            logic               w_up_en;   // all lower digits at BASE-1
            logic               w_dn_en;   // all lower digits at 0
            logic [DIGIT_W-1:0] w_next;

            assign w_d           = r_count[gi*DIGIT_W +: DIGIT_W];
            assign w_ld          = load_val[gi*DIGIT_W +: DIGIT_W];
            assign w_is_max[gi]  = (w_d == c_MAXD);
            assign w_is_zero[gi] = (w_d == '0);

            if (gi == 0) begin : g_lsd
                assign w_up_en = 1'b1;
                assign w_dn_en = 1'b1;
            end else begin : g_upper
                assign w_up_en = &w_is_max[gi-1:0];
                assign w_dn_en = &w_is_zero[gi-1:0];
            end

            assign w_next = up ? (w_up_en ? (w_is_max[gi]  ? '0     : w_d + 1'b1) : w_d)
                               : (w_dn_en ? (w_is_zero[gi] ? c_MAXD : w_d - 1'b1) : w_d);

            assign w_stepped[gi*DIGIT_W +: DIGIT_W] = w_next;
            assign w_loaded[gi*DIGIT_W +: DIGIT_W]  = ({1'b0, w_ld} >= c_BASE) ? c_MAXD : w_ld;
        end
    endgenerate

    // Terminal value depends on direction; tc ignores clr/load so a chained
    // instance sees the carry as soon as this one sits at its limit.
    assign w_at_term = up ? (&w_is_max) : (&w_is_zero);
    assign tc        = en & w_at_term;
    // An event only happens when the enable step is actually taken.
    assign w_step    = en & ~clr & ~load;
    assign w_event   = w_step & w_at_term;

    // Count register: clear beats load beats enable; saturate mode holds at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= w_loaded;
        end else if (en) begin
            if (!((SATURATE != 0) && w_at_term)) begin
                r_count <= w_stepped;
            end
        end
    end

    // Wrap pulse: high for the cycle after each wrap/saturation event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_event;
        end
    end

    // Sticky overflow: a new event wins over a simultaneous clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_event | (r_ovf & ~ovf_clr);
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: doc/cascade_counter.md
Name: cascade_counter

Overview:
- Parametrised multi-digit counter for the counter-to-7-segment datapath. Replaces the single-width binary counter.
- DIGITS cascaded digits, each counting modulo BASE (BASE=10 gives BCD), counting up or down.
- Supports synchronous clear and parallel load, and wraps or saturates at the limits.
- Outputs a packed digit vector that feeds per-digit 7-segment decoders directly, plus a cascade carry/borrow and overflow status.

Parameters:
- DIGITS, 4, number of cascaded digits (>=1).
- BASE, 10, modulus of each digit (2..2**DIGIT_W).
- DIGIT_W, 4, bits per digit.
- SATURATE, 0, overflow mode: 0 = wrap at the limits; 1 = hold at the limits.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset, asynchronous, active-low.
- en, in, 1, count enable, one step per cycle while high.
- up, in, 1, direction: 1 = increment, 0 = decrement.
- clr, in, 1, synchronous clear to zero.
- load, in, 1, synchronous parallel load.
- load_val, in, DIGITS*DIGIT_W, value to load; digit i occupies bits [i*DIGIT_W +: DIGIT_W].
- ovf_clr, in, 1, clears the ovf flag.
- count, out, DIGITS*DIGIT_W, current value, packed with the same layout as load_val.
- tc, out, 1, terminal count (combinational carry/borrow out for chaining another instance).
- wrap, out, 1, registered one-cycle pulse on a wrap or saturation event.
- ovf, out, 1, sticky overflow/underflow flag.

Behaviour:
- Reset (rst=0, asynchronous, any time, including mid-count):
  - count=0, wrap=0, ovf=0 immediately.
  - The first count step happens on the first rising clk edge with rst=1 and en=1.
- Priority per edge: clr > load > en. If none is asserted, count holds.
- clr=1: count=0. ovf is unaffected.
- load=1: count=load_val, but any digit value >= BASE is clamped to BASE-1. No wrap pulse is produced.
- Up-count (en=1, up=1):
  - Digit 0 steps every enabled cycle.
  - Digit i steps only when digits 0..i-1 are all BASE-1.
  - A digit at BASE-1 that steps goes to 0.
- Down-count (en=1, up=0):
  - Digit i steps only when digits 0..i-1 are all 0.
  - A digit at 0 that steps goes to BASE-1.
- Terminal value: MAX (all digits BASE-1) for up-count; 0 for down-count.
- tc = en & (count == terminal value for the current up). It is combinational and responds in the same cycle to en and up.
- At the terminal value with en=1:
  - SATURATE=0: count wraps (MAX->0 or 0->MAX). On the next cycle wrap=1 for exactly one cycle, and ovf is set.
  - SATURATE=1: count holds. wrap pulses and ovf is set exactly as in wrap mode.
- tc is not gated by clr or load. A wrap or ovf event happens only when the enable step is actually taken (no clr, no load that cycle).
- ovf:
  - Set by a wrap/saturation event.
  - Cleared by ovf_clr when there is no event that cycle.
  - A simultaneous event and ovf_clr leaves ovf=1 (set wins).
- Direction change takes effect on the next enabled edge. There is no extra latency and no lost step.
- Count latency: exactly 1 clock from an enabled edge to the updated count.
- Arithmetic is per digit. There is no binary carry across digit boundaries.
- Invalid digit values cannot arise except via load, and load clamps them.
- Legal configuration: DIGIT_W >= clog2(BASE). An elaboration-time check fails the build otherwise.

Test Plan:
1. Reset, then up-count (DIGITS=4, BASE=10, SATURATE=0): assert rst=0 for 2 cycles, release, en=1, up=1 for 1234 cycles -> count=16'h1234, wrap=0, ovf=0.
2. Up-count wrap: load 16'h9998, then en=1, up=1.
   - Edge 1: count=9999 and tc=1.
   - Edge 2: count=0000.
   - The following cycle: wrap=1 for exactly one cycle, then ovf=1 and stays high until an ovf_clr pulse clears it to 0.
3. Down-count borrow: load 16'h1000, up=0, 1 enabled step -> count=16'h0999. Continue to 0000, then one more step -> 9999 and ovf=1.
4. Saturate mode (SATURATE=1):
   - At 9999 with en=1, up=1 for 5 cycles -> count stays 9999, wrap pulses, ovf=1.
   - At 0000 with up=0 -> count holds at 0000.
5. Priority and clamp:
   - clr, load and en all asserted -> count=0.
   - load=1 with load_val=16'hC3F7 and en=1 -> count=16'h9397.
   - ovf_clr together with a wrap event -> ovf stays 1.
6. Async reset mid-count: at count=0567 with en=1, drop rst between clock edges -> count=0, wrap=0, ovf=0 immediately with no clock edge. After release, the first enabled edge gives 0001.
